// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the NCH-to-1 stream mux.
//   MODE_SEL / MODE_RR : values of the top-level mode input
//   clog2()            : index width for a channel count
//   nch_ok()           : true when a channel count is supported (2..16)
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit nch_ok(input int n);
    return (n >= 2) && (n <= 16);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin priority rotation.
//   in_valid [NCH]   request per channel
//   ptr      [SEL_W] last granted channel; search starts at ptr+1
//   grant    [NCH]   one-hot grant (zero when nothing requests)
//   gidx     [SEL_W] index of the granted channel
//   any      1       some channel was granted
module rr_arbiter #(
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic [NCH-1:0]   in_valid,
  input  logic [SEL_W-1:0] ptr,
  output logic [NCH-1:0]   grant,
  output logic [SEL_W-1:0] gidx,
  output logic             any
);

  // Two ascending passes: channels above ptr first, then the wrapped
  // range 0..ptr. Equivalent to a rotate without a variable index.
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!any && in_valid[i] && (SEL_W'(i) > ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        gidx     = SEL_W'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!any && in_valid[i] && (SEL_W'(i) <= ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        gidx     = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_n_to_1_stream.sv
// mux_n_to_1_stream: registered NCH-to-1 valid/ready stream multiplexer.
// Picks one channel by explicit select (mode=0) or round-robin (mode=1)
// and registers the winning beat into a single output stage.
//   clk, rst           clock, synchronous active-high reset
//   mode, sel          arbitration mode / explicit channel index
//   in_valid, in_data  per-channel beats, channel i at [i*WIDTH +: WIDTH]
//   in_last            end-of-packet, only meaningful with MUX_LOCK_EN
//   in_ready           per-channel accept, one-hot or zero
//   out_valid/data/ch  output register and its source channel
//   out_ready          downstream accept
// Build option: define MUX_LOCK_EN to hold arbitration on one channel
// from a beat with in_last=0 until its in_last=1 beat has transferred.
module mux_n_to_1_stream
  import mux_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_ch,
  input  logic                 out_ready
);

  if (!nch_ok(NCH)) begin : g_bad_nch
    $error("mux_n_to_1_stream: NCH must be in 2..16");
  end

  logic [SEL_W-1:0] rr_ptr;
  logic [NCH-1:0]   rr_grant;
  logic [SEL_W-1:0] rr_gidx;
  logic             rr_any;

  logic [NCH-1:0]   gnt;
  logic [SEL_W-1:0] gidx;
  logic             gany;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

`ifdef MUX_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_ch;
  logic             win_last;
`else
  logic             unused_last;
  assign unused_last = ^in_last;
`endif

  rr_arbiter #(.NCH(NCH), .SEL_W(SEL_W)) u_rr (
    .in_valid (in_valid),
    .ptr      (rr_ptr),
    .grant    (rr_grant),
    .gidx     (rr_gidx),
    .any      (rr_any)
  );

  // Grant is purely combinational from in_valid; sources hold data while
  // waiting, so a dropped valid simply drops the grant.
  always_comb begin
    gnt  = '0;
    gidx = '0;
    gany = 1'b0;
`ifdef MUX_LOCK_EN
    if (locked) begin
      gidx = lock_ch;
      for (int i = 0; i < NCH; i++)
        if (SEL_W'(i) == lock_ch) gnt[i] = in_valid[i];
      gany = |gnt;
    end else
`endif
    if (mode == MODE_RR) begin
      gnt  = rr_grant;
      gidx = rr_gidx;
      gany = rr_any;
    end else begin
      // sel values >= NCH match no channel and so grant nothing
      gidx = sel;
      for (int i = 0; i < NCH; i++)
        if (SEL_W'(i) == sel) gnt[i] = in_valid[i];
      gany = |gnt;
    end
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NCH; i++)
      if (SEL_W'(i) == gidx) mux_data = in_data[i*WIDTH +: WIDTH];
  end

`ifdef MUX_LOCK_EN
  always_comb begin
    win_last = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (SEL_W'(i) == gidx) win_last = in_last[i];
  end
`endif

  // Reset masks in_ready so nothing is accepted while the stage clears.
  assign load     = !out_valid || out_ready;
  assign xfer     = load && gany && !rst;
  assign in_ready = (load && !rst) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(NCH - 1);
    end else begin
      if (load) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= mux_data;
          out_ch   <= gidx;
        end
      end
      // Only round-robin transfers move the pointer, so explicit-select
      // traffic does not disturb the rotation order.
      if (xfer && mode == MODE_RR) rr_ptr <= gidx;
    end
  end

`ifdef MUX_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      locked  <= !win_last;
      lock_ch <= gidx;
    end
  end
`endif

endmodule
